// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side circular byte queue feeding a UART transmitter through a
// valid/data/busy handshake. Producers may push one byte per cycle; bytes are
// launched one at a time, never while the transmitter has a frame in flight.
// Fill level, full/empty flags and a dropped-write pulse support flow control.

module uart_tx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     i_wr_en,
   input  logic [DATA_BITS-1:0]     i_wr_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   input  logic                     i_tx_busy,
   output logic                     o_tx_valid,
   output logic [DATA_BITS-1:0]     o_tx_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   mem_q [DEPTH];
   logic [AW-1:0]          wrPtr_q, wrPtr_d;
   logic [AW-1:0]          rdPtr_q, rdPtr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic [DATA_BITS-1:0]   txData_q, txData_d;
   logic                   wrAccept;
   logic                   pop;
   logic                   txValid;

   // Flags come straight from the registered count so a same-cycle write or
   // pop can never influence the decisions made on them.
   assign o_full     = (count_q == FULL_LEVEL);
   assign o_empty    = (count_q == '0);
   assign o_count    = count_q;
   assign o_overflow = overflow_q;
   assign o_tx_data  = txData_q;
   assign o_tx_valid = txValid;

   // Launch sequencer: pop only from IDLE, pulse valid in LAUNCH, then wait for
   // the transmitter's busy flag to rise and fall before considering the next byte.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      txValid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!o_empty && !i_tx_busy) begin
               pop     = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            txValid = 1'b1;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Queue bookkeeping: accepted writes advance the write pointer, pops advance
   // the read pointer and capture the byte, and a refused write arms the overflow pulse.
   always_comb begin
      wrAccept   = i_wr_en && !o_full;
      overflow_d = i_wr_en && o_full;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      txData_d   = txData_q;
      if (wrAccept) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (pop) begin
         rdPtr_d  = rdPtr_q + AW'(1);
         txData_d = mem_q[rdPtr_q];
      end
      case ({wrAccept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State and control registers; reset discards everything queued, even mid-frame.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         txData_q   <= '0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         txData_q   <= txData_d;
      end
   end

   // Storage array needs no reset; stale contents are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (n_rst && wrAccept) begin
         mem_q[wrPtr_q] <= i_wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Drives uart_tx_fifo with a behavioural transmitter (busy for FRAME cycles,
// starting the cycle after it accepts a byte) and compares launched bytes and
// launch timing against a reference queue built from the queue rules.

module tb_uart_tx_fifo;

   localparam int DATA_BITS = 8;
   localparam int DEPTH     = 16;
   localparam int CW        = $clog2(DEPTH) + 1;
   localparam int FRAME     = 20;

   logic                 clk = 1'b0;
   logic                 n_rst;
   logic                 i_wr_en;
   logic [DATA_BITS-1:0] i_wr_data;
   logic                 o_full;
   logic                 o_empty;
   logic [CW-1:0]        o_count;
   logic                 o_overflow;
   logic                 i_tx_busy = 1'b0;
   logic                 o_tx_valid;
   logic [DATA_BITS-1:0] o_tx_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit holdBusy = 1'b0;
   bit acceptPending = 1'b0;
   int busyLeft = 0;

   logic [DATA_BITS-1:0] launched[$];
   int                   launchCyc[$];
   int                   fallCyc[$];
   logic [DATA_BITS-1:0] refQ[$];

   uart_tx_fifo #(
      .DATA_BITS(DATA_BITS),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .i_wr_en(i_wr_en),
      .i_wr_data(i_wr_data),
      .o_full(o_full),
      .o_empty(o_empty),
      .o_count(o_count),
      .o_overflow(o_overflow),
      .i_tx_busy(i_tx_busy),
      .o_tx_valid(o_tx_valid),
      .o_tx_data(o_tx_data)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: records each launch and holds busy for FRAME cycles
   // from the cycle after it accepted the byte.
   always @(negedge clk) begin
      if (!n_rst) begin
         acceptPending = 1'b0;
         busyLeft      = 0;
         i_tx_busy     = 1'b0;
      end else begin
         if (acceptPending) begin
            busyLeft      = FRAME;
            acceptPending = 1'b0;
         end else if (busyLeft > 0) begin
            busyLeft = busyLeft - 1;
            if (busyLeft == 0) fallCyc.push_back(cyc);
         end
         if (o_tx_valid === 1'b1) begin
            acceptPending = 1'b1;
            launched.push_back(o_tx_data);
            launchCyc.push_back(cyc);
         end
         i_tx_busy = holdBusy || (busyLeft > 0);
      end
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearLogs();
      launched.delete();
      launchCyc.delete();
      fallCyc.delete();
      refQ.delete();
   endtask

   task automatic test_reset();
      n_rst   = 1'b0;
      i_wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_wr_data = 8'($urandom);
         tick();
         checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty actual=%b required=1", o_empty); end
         checks++; if (o_count !== '0) begin errors++; $display("[TB] FAIL reset_count actual=%0d required=0", o_count); end
         checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b required=0", o_tx_valid); end
         checks++; if (o_tx_data !== '0) begin errors++; $display("[TB] FAIL reset_data actual=%0h required=0", o_tx_data); end
         checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow actual=%b required=0", o_overflow); end
         checks++; if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full actual=%b required=0", o_full); end
      end
      n_rst   = 1'b1;
      i_wr_en = 1'b0;
      tick();
      checks++; if (o_count !== '0) begin errors++; $display("[TB] FAIL reset_release_count actual=%0d required=0", o_count); end
   endtask

   task automatic test_single_byte();
      int wrCyc;
      clearLogs();
      i_wr_en   = 1'b1;
      i_wr_data = 8'hA5;
      wrCyc     = cyc;
      tick();
      i_wr_en = 1'b0;
      checks++; if (o_count !== CW'(1)) begin errors++; $display("[TB] FAIL single_count_after_write actual=%0d required=1", o_count); end
      for (int i = 0; i < 50 && launched.size() == 0; i++) tick();
      checks++;
      if (launched.size() != 1) begin
         errors++; $display("[TB] FAIL single_launch_seen actual=%0d required=1", launched.size());
      end else begin
         checks++; if (launched[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_data actual=%0h required=a5", launched[0]); end
         checks++; if (launchCyc[0] != wrCyc + 2) begin errors++; $display("[TB] FAIL single_latency actual=%0d required=%0d", launchCyc[0] - wrCyc, 2); end
      end
      repeat (FRAME + 10) tick();
      checks++; if (launched.size() != 1) begin errors++; $display("[TB] FAIL single_pulse_count actual=%0d required=1", launched.size()); end
      checks++; if (o_count !== '0) begin errors++; $display("[TB] FAIL single_count_final actual=%0d required=0", o_count); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_final actual=%b required=1", o_empty); end
   endtask

   task automatic test_burst();
      clearLogs();
      for (int i = 0; i < DEPTH; i++) begin
         i_wr_en   = 1'b1;
         i_wr_data = 8'(i);
         refQ.push_back(8'(i));
         tick();
      end
      i_wr_en = 1'b0;
      checks++; if (o_count !== CW'(DEPTH - 1)) begin errors++; $display("[TB] FAIL burst_count actual=%0d required=%0d", o_count, DEPTH - 1); end
      for (int i = 0; i < DEPTH * (FRAME + 6) + 50 && launched.size() < DEPTH; i++) tick();
      checks++;
      if (launched.size() != DEPTH) begin
         errors++; $display("[TB] FAIL burst_launches actual=%0d required=%0d", launched.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            checks++; if (launched[i] !== refQ[i]) begin errors++; $display("[TB] FAIL burst_order idx=%0d actual=%0h required=%0h", i, launched[i], refQ[i]); end
         end
         for (int i = 1; i < DEPTH; i++) begin
            checks++; if (launchCyc[i] - fallCyc[i-1] != 2) begin errors++; $display("[TB] FAIL burst_gap idx=%0d actual=%0d required=2", i, launchCyc[i] - fallCyc[i-1]); end
         end
      end
      repeat (FRAME + 10) tick();
   endtask

   task automatic test_full_overflow();
      clearLogs();
      holdBusy = 1'b1;
      tick();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         i_wr_en   = 1'b1;
         i_wr_data = 8'($urandom);
         refQ.push_back(i_wr_data);
         tick();
      end
      checks++; if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag actual=%b required=1", o_full); end
      checks++; if (o_count !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL full_count actual=%0d required=%0d", o_count, DEPTH); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_no_early_overflow actual=%b required=0", o_overflow); end
      i_wr_data = 8'($urandom);
      tick();
      i_wr_en = 1'b0;
      checks++; if (o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_pulse actual=%b required=1", o_overflow); end
      checks++; if (o_count !== CW'(DEPTH)) begin errors++; $display("[TB] FAIL overflow_count actual=%0d required=%0d", o_count, DEPTH); end
      tick();
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_one_cycle actual=%b required=0", o_overflow); end
      checks++; if (launched.size() != 0) begin errors++; $display("[TB] FAIL full_launch_while_busy actual=%0d required=0", launched.size()); end
      holdBusy = 1'b0;
      for (int i = 0; i < DEPTH * (FRAME + 6) + 50 && launched.size() < DEPTH; i++) tick();
      repeat (FRAME + 10) tick();
      checks++;
      if (launched.size() != DEPTH) begin
         errors++; $display("[TB] FAIL full_drain_count actual=%0d required=%0d", launched.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            checks++; if (launched[i] !== refQ[i]) begin errors++; $display("[TB] FAIL full_drain_order idx=%0d actual=%0h required=%0h", i, launched[i], refQ[i]); end
         end
      end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_empty actual=%b required=1", o_empty); end
   endtask

   task automatic test_wrap();
      int accepted;
      int pops;
      int level;
      bit expOvf;
      clearLogs();
      accepted = 0;
      expOvf   = 1'b0;
      for (int c = 0; c < 4000 && accepted < 4 * DEPTH; c++) begin
         pops  = launched.size() + ((o_tx_valid === 1'b1) ? 1 : 0);
         level = accepted - pops;
         checks++; if (o_count !== CW'(level)) begin errors++; $display("[TB] FAIL wrap_count cyc=%0d actual=%0d required=%0d", cyc, o_count, level); end
         checks++; if (o_overflow !== expOvf) begin errors++; $display("[TB] FAIL wrap_overflow cyc=%0d actual=%b required=%b", cyc, o_overflow, expOvf); end
         if ($urandom_range(3) != 0) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'($urandom);
            if (level < DEPTH) begin
               refQ.push_back(i_wr_data);
               accepted++;
               expOvf = 1'b0;
            end else begin
               expOvf = 1'b1;
            end
         end else begin
            i_wr_en = 1'b0;
            expOvf  = 1'b0;
         end
         tick();
      end
      i_wr_en = 1'b0;
      checks++; if (accepted < 4 * DEPTH) begin errors++; $display("[TB] FAIL wrap_progress actual=%0d required=%0d", accepted, 4 * DEPTH); end
      for (int i = 0; i < DEPTH * (FRAME + 6) + 100 && launched.size() < accepted; i++) tick();
      repeat (FRAME + 10) tick();
      checks++;
      if (launched.size() != refQ.size()) begin
         errors++; $display("[TB] FAIL wrap_total actual=%0d required=%0d", launched.size(), refQ.size());
      end else begin
         for (int i = 0; i < refQ.size(); i++) begin
            checks++; if (launched[i] !== refQ[i]) begin errors++; $display("[TB] FAIL wrap_order idx=%0d actual=%0h required=%0h", i, launched[i], refQ[i]); end
         end
      end
   endtask

   task automatic test_midframe_reset();
      logic [DATA_BITS-1:0] fresh;
      clearLogs();
      for (int i = 0; i < 6; i++) begin
         i_wr_en   = 1'b1;
         i_wr_data = 8'($urandom);
         refQ.push_back(i_wr_data);
         tick();
      end
      i_wr_en = 1'b0;
      for (int i = 0; i < 50 && !(launched.size() == 1 && i_tx_busy === 1'b1); i++) tick();
      tick();
      tick();
      checks++; if (o_count !== CW'(5)) begin errors++; $display("[TB] FAIL midreset_queued actual=%0d required=5", o_count); end
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      checks++; if (o_count !== '0) begin errors++; $display("[TB] FAIL midreset_count actual=%0d required=0", o_count); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL midreset_empty actual=%b required=1", o_empty); end
      checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid actual=%b required=0", o_tx_valid); end
      checks++; if (o_tx_data !== '0) begin errors++; $display("[TB] FAIL midreset_data actual=%0h required=0", o_tx_data); end
      launched.delete();
      repeat (30) tick();
      checks++; if (launched.size() != 0) begin errors++; $display("[TB] FAIL midreset_no_launch actual=%0d required=0", launched.size()); end
      fresh     = 8'($urandom);
      i_wr_en   = 1'b1;
      i_wr_data = fresh;
      tick();
      i_wr_en = 1'b0;
      for (int i = 0; i < 50 && launched.size() == 0; i++) tick();
      checks++;
      if (launched.size() != 1) begin
         errors++; $display("[TB] FAIL midreset_relaunch actual=%0d required=1", launched.size());
      end else begin
         checks++; if (launched[0] !== fresh) begin errors++; $display("[TB] FAIL midreset_relaunch_data actual=%0h required=%0h", launched[0], fresh); end
      end
      repeat (FRAME + 10) tick();
   endtask

   // Scenario sequence.
   initial begin
      n_rst     = 1'b0;
      i_wr_en   = 1'b0;
      i_wr_data = '0;
      test_reset();
      test_single_byte();
      test_burst();
      test_full_overflow();
      test_wrap();
      test_midframe_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte queue that sits directly upstream of the UART transmitter. Producers (CPU bus, debug console, test pattern generator) push bytes at system-clock rate. The block buffers them in a circular FIFO and launches them one at a time into the transmitter's valid/data/busy interface, never presenting a new byte while a frame is in flight. It decouples bursty producers from the slow serial line and reports full/empty/fill level for flow control.

## Interface
Parameters:
- DATA_BITS, 8, byte width; must match the transmitter's DATA_BITS.
- DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- i_wr_en  in  1  write strobe; one byte per cycle.
- i_wr_data  in  DATA_BITS  byte to enqueue.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_count  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
- o_overflow  out  1  one-cycle pulse: write attempted while full, byte dropped.
- i_tx_busy  in  1  transmitter busy (high from the cycle after it accepts a byte until the frame's stop bit completes).
- o_tx_valid  out  1  one-cycle launch pulse to the transmitter.
- o_tx_data  out  DATA_BITS  byte presented with o_tx_valid; held stable until the next launch.

## Operation
- Storage: DEPTH x DATA_BITS memory, write pointer, read pointer ($clog2(DEPTH) bits each, natural wrap DEPTH-1 -> 0), count register.
- Write accepted iff i_wr_en && !o_full (registered full flag). Accepted write stores at wr_ptr, wr_ptr+1.
- Write while full: byte dropped, pointers/count unchanged, o_overflow=1 next cycle for one cycle.
- Pop occurs only on the IDLE->LAUNCH transition: o_tx_data <= mem[rd_ptr], rd_ptr+1.
- Count: +1 on accepted write only, -1 on pop only, unchanged on simultaneous write+pop. Never exceeds DEPTH, never below 0.
- o_full = (count == DEPTH), o_empty = (count == 0), derived from the registered count.
- Launch FSM, states:
  - IDLE: if !o_empty && !i_tx_busy, pop and go to LAUNCH.
  - LAUNCH: o_tx_valid=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: stay until i_tx_busy=1, then go to WAIT_DONE. This guards against re-launching before the transmitter's busy flag rises.
  - WAIT_DONE: stay until i_tx_busy=0, then go to IDLE.
- o_tx_valid is high only in LAUNCH. The launch decision uses registered o_empty, so a write to an empty FIFO cannot launch in its own cycle.
- Simultaneous write and pop when full: the write is refused (full is registered), and the pop proceeds.
- Reset (n_rst=0 at an edge, including mid-frame): pointers=0, count=0, FSM=IDLE, queued bytes discarded.
  - Output values after reset: o_empty=1, o_full=0, o_count=0, o_overflow=0, o_tx_valid=0, o_tx_data=0.
  - The transmitter shares this reset, so no partial frame continues.

## Timing
- First-byte latency: write accepted at edge E0. Count/o_empty update after E0. FSM enters LAUNCH after E1. o_tx_valid is high in the cycle after E1.
- The transmitter samples valid at E2. i_tx_busy is high after E2, so the FSM leaves WAIT_BUSY after E3.
- Back-to-back frames: i_tx_busy falls in cycle M.
  - The FSM goes to IDLE after that edge, then to LAUNCH one edge later.
  - The next o_tx_valid pulse comes exactly 2 cycles after busy falls.
- o_count/o_full/o_empty reflect the accepted write or pop one cycle after the edge where it occurs.
- Sustained write rate: 1 byte/cycle until full. Drain rate is limited by the serial frame time only.

## Test plan
- Reset: hold n_rst=0 for 3 cycles with i_wr_en=1 -> o_empty=1, o_count=0, o_tx_valid=0, o_tx_data=0, no overflow pulse.
- Single byte: write 0xA5 into empty FIFO with a transmitter model (busy one cycle after valid, for 20 cycles) -> o_tx_valid pulse 2 cycles after write edge, o_tx_data=0xA5, exactly one pulse, o_count returns 0.
- Burst: write 0x00..0x0F in 16 consecutive cycles (DEPTH=16) -> bytes launched in order 0x00..0x0F, one launch per busy window, each launch 2 cycles after busy falls.
- Full/overflow: hold i_tx_busy=1 and write 17 bytes -> o_full=1 and o_count=16 after the 16th write; 17th write raises o_overflow for one cycle and is absent from output.
- Wrap and simultaneous: with count=16, write during the pop cycle (refused), then write after count drops. Repeat across 3 pointer wraps -> output sequence matches a reference queue with no loss or duplication.
- Mid-frame reset: assert n_rst=0 while in WAIT_DONE with 5 bytes queued -> FSM IDLE, o_count=0. After release, no launch until a new write.
